// File: rtl/flag_branch_ctrl_pkg.sv
// cpu_pkg: types and constants shared by the flag/branch control slice.
//   br_type_t : branch kind decoded in ID (none, B, B.cond, CBZ)
//   cond_t    : the 16 condition codes evaluated by B.cond
//   state_t   : flag-scheduling FSM states (RESOLVE, WAIT)
//   FLAG_*    : bit positions of N, Z, C, V inside the 4-bit NZCV vector
//   ZGROUP_W  : group width of the zero-detect NOR tree
package cpu_pkg;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_B    = 2'b01,
        BR_COND = 2'b10,
        BR_CBZ  = 2'b11
    } br_type_t;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_t;

    typedef enum logic {
        RESOLVE = 1'b0,
        WAIT    = 1'b1
    } state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int ZGROUP_W = 16;

    function automatic logic [3:0] pack_nzcv(input logic n, input logic z,
                                             input logic c, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/flag_branch_ctrl_if.sv
// flag_branch_ctrl_if: groups the EX/ID pipeline inputs and the branch
// control outputs of flag_branch_ctrl.
//   master : pipeline side, drives EX/ID fields, observes flags/branch/stall
//   slave  : flag_branch_ctrl side
// Fields:
//   ex_valid, ex_set_flags, ex_result[DATA_W], ex_carry, ex_overflow
//   id_valid, id_br_type[2], id_cond[4], id_cbz_data[DATA_W]
//   flags[4] (NZCV), br_taken, flag_stall, stall_count[CNT_W]
interface flag_branch_ctrl_if #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
);
    logic              ex_valid;
    logic              ex_set_flags;
    logic [DATA_W-1:0] ex_result;
    logic              ex_carry;
    logic              ex_overflow;
    logic              id_valid;
    logic [1:0]        id_br_type;
    logic [3:0]        id_cond;
    logic [DATA_W-1:0] id_cbz_data;
    logic [3:0]        flags;
    logic              br_taken;
    logic              flag_stall;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output ex_valid, ex_set_flags, ex_result, ex_carry, ex_overflow,
        output id_valid, id_br_type, id_cond, id_cbz_data,
        input  flags, br_taken, flag_stall, stall_count
    );

    modport slave (
        input  ex_valid, ex_set_flags, ex_result, ex_carry, ex_overflow,
        input  id_valid, id_br_type, id_cond, id_cbz_data,
        output flags, br_taken, flag_stall, stall_count
    );
endinterface

// File: rtl/flag_branch_ctrl_cond.sv
// cond_eval: purely combinational condition-code evaluator.
//   cond  : 4-bit condition code (cond_t encoding)
//   nzcv  : flag vector, bit3=N bit2=Z bit1=C bit0=V
//   taken : 1 when the condition holds
// NV is treated the same as AL (always true).
module cond_eval
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       taken
);

    logic n;
    logic z;
    logic c;
    logic v;

    assign n = nzcv[FLAG_N];
    assign z = nzcv[FLAG_Z];
    assign c = nzcv[FLAG_C];
    assign v = nzcv[FLAG_V];

    always_comb begin
        taken = 1'b0;
        case (cond_t'(cond))
            COND_EQ: taken = z;
            COND_NE: taken = ~z;
            COND_CS: taken = c;
            COND_CC: taken = ~c;
            COND_MI: taken = n;
            COND_PL: taken = ~n;
            COND_VS: taken = v;
            COND_VC: taken = ~v;
            COND_HI: taken = c & ~z;
            COND_LS: taken = ~c | z;
            COND_GE: taken = (n == v);
            COND_LT: taken = (n != v);
            COND_GT: taken = ~z & (n == v);
            COND_LE: taken = z | (n != v);
            COND_AL: taken = 1'b1;
            COND_NV: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_branch_ctrl.sv
// flag_branch_ctrl: owns the NZCV flag register and resolves B, B.cond and
// CBZ in ID, scheduling flag availability for B.cond either by forwarding
// the EX-stage flags (FWD_EX_FLAGS=1) or by a one-cycle IF/ID stall.
// Ports:
//   clk   : system clock, all state on rising edge
//   reset : synchronous, active-high
//   bus   : flag_branch_ctrl_if.slave (EX/ID inputs, flags, br_taken,
//           flag_stall, stall_count outputs)
module flag_branch_ctrl
    import cpu_pkg::*;
#(
    parameter int DATA_W       = 64,
    parameter bit FWD_EX_FLAGS = 1'b0,
    parameter int CNT_W        = 16
) (
    input logic               clk,
    input logic               reset,
    flag_branch_ctrl_if.slave bus
);

    localparam int NGRP = (DATA_W + ZGROUP_W - 1) / ZGROUP_W;

    // NOR per 16-bit group, then AND of group results; shared by Z and CBZ.
    function automatic logic is_zero(input logic [DATA_W-1:0] value);
        logic [NGRP*ZGROUP_W-1:0] padded;
        logic [NGRP-1:0]          grp_zero;
        padded             = '0;
        padded[DATA_W-1:0] = value;
        for (int g = 0; g < NGRP; g++) begin
            grp_zero[g] = ~|padded[g*ZGROUP_W +: ZGROUP_W];
        end
        return &grp_zero;
    endfunction

    state_t           state;
    state_t           state_next;
    logic [3:0]       flags_q;
    logic [3:0]       next_flags;
    logic [3:0]       eff_flags;
    logic [CNT_W-1:0] stall_count_q;
    logic             capture;
    logic             cond_hazard;
    logic             cond_taken;
    logic             cbz_zero;
    logic             flag_stall;
    logic             br_taken;

    assign capture    = bus.ex_valid & bus.ex_set_flags;
    assign next_flags = pack_nzcv(bus.ex_result[DATA_W-1], is_zero(bus.ex_result),
                                  bus.ex_carry, bus.ex_overflow);
    assign eff_flags  = (FWD_EX_FLAGS && capture) ? next_flags : flags_q;
    assign cbz_zero   = is_zero(bus.id_cbz_data);

    // A B.cond in ID racing a flag-setter in EX only matters without forwarding.
    assign cond_hazard = !FWD_EX_FLAGS && bus.id_valid &&
                         (br_type_t'(bus.id_br_type) == BR_COND) && capture;

    cond_eval u_cond_eval (
        .cond  (bus.id_cond),
        .nzcv  (eff_flags),
        .taken (cond_taken)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RESOLVE;
        end else begin
            state <= state_next;
        end
    end

    // WAIT always falls back to RESOLVE so a held B.cond never re-stalls.
    always_comb begin
        state_next = state;
        case (state)
            RESOLVE: if (cond_hazard) state_next = WAIT;
            WAIT:    state_next = RESOLVE;
            default: state_next = RESOLVE;
        endcase
    end

    always_comb begin
        flag_stall = 1'b0;
        br_taken   = 1'b0;
        if (!reset) begin
            if (state == RESOLVE && cond_hazard) begin
                flag_stall = 1'b1;
            end
            if (bus.id_valid && !flag_stall) begin
                case (br_type_t'(bus.id_br_type))
                    BR_B:    br_taken = 1'b1;
                    BR_COND: br_taken = cond_taken;
                    BR_CBZ:  br_taken = cbz_zero;
                    default: br_taken = 1'b0;
                endcase
            end
        end
    end

    // Reset wins over a capture presented on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else if (capture) begin
            flags_q <= next_flags;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_q <= '0;
        end else if (flag_stall && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_q <= stall_count_q + CNT_W'(1);
        end
    end

    assign bus.flags       = flags_q;
    assign bus.br_taken    = br_taken;
    assign bus.flag_stall  = flag_stall;
    assign bus.stall_count = stall_count_q;

endmodule

// File: tb/tb_flag_branch_ctrl.sv
// tb_flag_branch_ctrl: runs two flag_branch_ctrl instances side by side on
// identical stimulus, one stalling (FWD_EX_FLAGS=0) and one forwarding
// (FWD_EX_FLAGS=1), both with a narrow stall counter so saturation is
// reachable. A behavioural model tracks flags, the pending-stall cycle and
// the stall counter and is compared every cycle; directed literal checks
// pin the model. cond_eval is also swept standalone over all 256 inputs.
module tb_flag_branch_ctrl;

    localparam int DW    = 64;
    localparam int CW    = 6;
    localparam int CSAT  = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          ex_valid;
    logic          ex_set_flags;
    logic [DW-1:0] ex_result;
    logic          ex_carry;
    logic          ex_overflow;
    logic          id_valid;
    logic [1:0]    id_br_type;
    logic [3:0]    id_cond;
    logic [DW-1:0] id_cbz_data;

    flag_branch_ctrl_if #(.DATA_W(DW), .CNT_W(CW)) bus0 ();
    flag_branch_ctrl_if #(.DATA_W(DW), .CNT_W(CW)) bus1 ();

    assign bus0.ex_valid     = ex_valid;
    assign bus0.ex_set_flags = ex_set_flags;
    assign bus0.ex_result    = ex_result;
    assign bus0.ex_carry     = ex_carry;
    assign bus0.ex_overflow  = ex_overflow;
    assign bus0.id_valid     = id_valid;
    assign bus0.id_br_type   = id_br_type;
    assign bus0.id_cond      = id_cond;
    assign bus0.id_cbz_data  = id_cbz_data;
    assign bus1.ex_valid     = ex_valid;
    assign bus1.ex_set_flags = ex_set_flags;
    assign bus1.ex_result    = ex_result;
    assign bus1.ex_carry     = ex_carry;
    assign bus1.ex_overflow  = ex_overflow;
    assign bus1.id_valid     = id_valid;
    assign bus1.id_br_type   = id_br_type;
    assign bus1.id_cond      = id_cond;
    assign bus1.id_cbz_data  = id_cbz_data;

    flag_branch_ctrl #(.DATA_W(DW), .FWD_EX_FLAGS(1'b0), .CNT_W(CW)) dut_stall (
        .clk   (clk),
        .reset (rst),
        .bus   (bus0)
    );

    flag_branch_ctrl #(.DATA_W(DW), .FWD_EX_FLAGS(1'b1), .CNT_W(CW)) dut_fwd (
        .clk   (clk),
        .reset (rst),
        .bus   (bus1)
    );

    logic [3:0] ce_cond;
    logic [3:0] ce_nzcv;
    logic       ce_taken;

    cond_eval u_ce (
        .cond  (ce_cond),
        .nzcv  (ce_nzcv),
        .taken (ce_taken)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: index 0 = stalling instance, 1 = forwarding one
    // ------------------------------------------------------------------
    logic [3:0] m_flags [2];
    bit         m_held  [2];
    int         m_count [2];
    bit         m_valid = 0;

    // Conditions come in true/false pairs: the even code is the base test,
    // the odd code its inverse, except the last pair which is always true.
    function automatic bit cond_model(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, r;
        n  = f[3];
        z  = f[2];
        cy = f[1];
        v  = f[0];
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cy;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cy && !z;
            3'd5: r = (n == v);
            3'd6: r = !z && (n == v);
            default: r = 1'b1;
        endcase
        if (c[3:1] != 3'd7 && c[0]) r = !r;
        return r;
    endfunction

    function automatic logic [3:0] ex_flags_model();
        return {ex_result[DW-1], (ex_result == 0), ex_carry, ex_overflow};
    endfunction

    function automatic bit model_stall(input int d);
        return !rst && d == 0 && !m_held[d] && id_valid && id_br_type == 2'd2 &&
               ex_valid && ex_set_flags;
    endfunction

    function automatic bit model_taken(input int d);
        logic [3:0] f;
        if (rst || !id_valid || model_stall(d)) return 1'b0;
        f = (d == 1 && ex_valid && ex_set_flags) ? ex_flags_model() : m_flags[d];
        case (id_br_type)
            2'd1:    return 1'b1;
            2'd2:    return cond_model(id_cond, f);
            2'd3:    return id_cbz_data == 0;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_flags[d] = 4'b0000;
                m_held[d]  = 0;
                m_count[d] = 0;
            end else begin
                bit st;
                st = model_stall(d);
                if (st && m_count[d] < CSAT) m_count[d]++;
                m_held[d] = st;
                if (ex_valid && ex_set_flags) m_flags[d] = ex_flags_model();
            end
        end
        if (rst) m_valid = 1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check_output("d0.flags",       bus0.flags,       m_flags[0]);
            check_output("d0.br_taken",    bus0.br_taken,    model_taken(0));
            check_output("d0.flag_stall",  bus0.flag_stall,  model_stall(0));
            check_output("d0.stall_count", bus0.stall_count, m_count[0]);
            check_output("d1.flags",       bus1.flags,       m_flags[1]);
            check_output("d1.br_taken",    bus1.br_taken,    model_taken(1));
            check_output("d1.flag_stall",  bus1.flag_stall,  model_stall(1));
            check_output("d1.stall_count", bus1.stall_count, m_count[1]);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic apply_stimulus(input logic r, input logic ev, input logic es,
                                  input logic [DW-1:0] res, input logic c,
                                  input logic o, input logic iv,
                                  input logic [1:0] bt, input logic [3:0] cond,
                                  input logic [DW-1:0] cbz);
        @(posedge clk);
        #1;
        rst          = r;
        ex_valid     = ev;
        ex_set_flags = es;
        ex_result    = res;
        ex_carry     = c;
        ex_overflow  = o;
        id_valid     = iv;
        id_br_type   = bt;
        id_cond      = cond;
        id_cbz_data  = cbz;
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] x;
        case ($urandom_range(0, 3))
            0: x = '0;
            1: x = {1'b1, 31'($urandom), 32'($urandom)};
            2: x = 64'd1 << $urandom_range(0, DW - 1);
            default: x = {32'($urandom), 32'($urandom)};
        endcase
        return x;
    endfunction

    task automatic apply_random(input logic r);
        apply_stimulus(r, ($urandom_range(0, 3) != 0), 1'($urandom), rand_data(),
                       1'($urandom), 1'($urandom), ($urandom_range(0, 7) != 0),
                       2'($urandom), 4'($urandom), rand_data());
    endtask

    localparam logic [DW-1:0] MSB_ONLY = 64'h8000_0000_0000_0000;
    localparam logic [DW-1:0] BIT48    = 64'h0001_0000_0000_0000;

    initial begin
        rst = 1'b1;
        ex_valid = 0; ex_set_flags = 0; ex_result = '0; ex_carry = 0;
        ex_overflow = 0; id_valid = 0; id_br_type = 0; id_cond = 0; id_cbz_data = '0;
        ce_cond = 0; ce_nzcv = 0;

        // Reset for two cycles under random inputs
        apply_random(1'b1);
        apply_random(1'b1);
        @(negedge clk);
        check_output("reset.flags",       bus0.flags,       64'h0);
        check_output("reset.br_taken",    bus0.br_taken,    64'h0);
        check_output("reset.flag_stall",  bus0.flag_stall,  64'h0);
        check_output("reset.stall_count", bus0.stall_count, 64'h0);

        // SUBS -> zero with carry, then B.cond EQ with EX idle
        apply_stimulus(0, 1, 1, '0, 1, 0, 0, 2'd0, 4'h0, '1);
        apply_stimulus(0, 0, 0, '1, 0, 0, 1, 2'd2, 4'h0, '1);
        @(negedge clk);
        check_output("eq.flags",    bus0.flags,      64'h6);
        check_output("eq.taken",    bus0.br_taken,   64'h1);
        check_output("eq.stall",    bus0.flag_stall, 64'h0);
        check_output("eq.fwdtaken", bus1.br_taken,   64'h1);

        // SUBS -> negative alongside B.cond MI
        apply_stimulus(0, 1, 1, MSB_ONLY, 0, 0, 1, 2'd2, 4'h4, '1);
        @(negedge clk);
        check_output("mi.stall",     bus0.flag_stall, 64'h1);
        check_output("mi.taken",     bus0.br_taken,   64'h0);
        check_output("mi.fwd_stall", bus1.flag_stall, 64'h0);
        check_output("mi.fwd_taken", bus1.br_taken,   64'h1);
        apply_stimulus(0, 0, 0, '0, 0, 0, 1, 2'd2, 4'h4, '1);
        @(negedge clk);
        check_output("mi_wait.flags", bus0.flags,       64'h8);
        check_output("mi_wait.taken", bus0.br_taken,    64'h1);
        check_output("mi_wait.stall", bus0.flag_stall,  64'h0);
        check_output("mi_wait.count", bus0.stall_count, 64'h1);

        // CBZ with a flag-setter in EX never stalls
        apply_stimulus(0, 1, 1, '0, 0, 0, 1, 2'd3, 4'h0, '0);
        @(negedge clk);
        check_output("cbz0.taken", bus0.br_taken,   64'h1);
        check_output("cbz0.stall", bus0.flag_stall, 64'h0);
        apply_stimulus(0, 1, 1, '0, 0, 0, 1, 2'd3, 4'h0, BIT48);
        @(negedge clk);
        check_output("cbz48.taken", bus0.br_taken,   64'h0);
        check_output("cbz48.stall", bus0.flag_stall, 64'h0);
        apply_stimulus(0, 1, 1, '0, 0, 0, 1, 2'd3, 4'h0, MSB_ONLY);
        @(negedge clk);
        check_output("cbz63.taken", bus0.br_taken,   64'h0);
        check_output("cbz63.stall", bus0.flag_stall, 64'h0);

        // Random traffic with occasional resets, including mid-WAIT
        for (int i = 0; i < 2000; i++) begin
            apply_random($urandom_range(0, 63) == 0);
        end

        // Saturate the stall counter on the stalling instance
        apply_random(1'b1);
        for (int i = 0; i < 2 * (CSAT + 4) + 6; i++) begin
            apply_stimulus(0, 1, 1, rand_data(), 1'($urandom), 1'($urandom),
                           1, 2'd2, 4'($urandom), rand_data());
        end
        @(negedge clk);
        check_output("sat.count",     bus0.stall_count, 64'(CSAT));
        check_output("sat.fwd_count", bus1.stall_count, 64'h0);

        // Standalone cond_eval sweep over every code and flag value
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                ce_cond = 4'(c);
                ce_nzcv = 4'(f);
                #1;
                check_output($sformatf("cond%0h_nzcv%0h", c, f), ce_taken,
                             cond_model(4'(c), 4'(f)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
